// File: rtl/vram_dma_pkg.sv
// Shared types and constants for the SDRAM-to-VRAM bulk copier.
package vram_dma_pkg;

  localparam int VRAM_DMA_DATA_W     = 128;
  localparam int VRAM_DMA_BYTE_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } dma_state_t;

endpackage

// File: rtl/vram_dma_credit.sv
// Outstanding-read tracker: counts accepted-but-unreturned reads and flags full.
// Latency: count updates on the clock after inc/dec; full is a direct decode of the count.
// Backpressure: full blocks further issue; inc while full and dec while empty are ignored.
module vram_dma_credit #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [CW-1:0] cnt;
  logic          inc_ok;
  logic          dec_ok;

  assign full   = (cnt == CW'(MAX_OUTSTANDING));
  assign inc_ok = inc && !full;
  assign dec_ok = dec && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case ({inc_ok, dec_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/vram_dma_engine.sv
// Copies a WORDS x 128-bit image from SDRAM (Avalon-MM read master) into VRAM, in order. Optional macro VRAM_DMA_PERF_EN adds dma_cycles.
// Latency: one cycle from avm_readdatavalid to h2f_vram_wren; the finish pulse coincides with the last write.
// Backpressure: address/read held under avm_waitrequest; at most MAX_OUTSTANDING reads in flight.
module vram_dma_engine
  import vram_dma_pkg::*;
#(
  parameter int WORDS           = 4096,
  parameter int VRAM_AW         = 12,
  parameter int MAX_OUTSTANDING = 8,
  parameter int SDRAM_AW        = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                dma_engine_src_addr,
  input  logic                       dma_engine_start,
  output logic                       dma_engine_finish,
  output logic                       dma_busy,
  output logic [SDRAM_AW-1:0]        avm_address,
  output logic                       avm_read,
  input  logic                       avm_waitrequest,
  input  logic [VRAM_DMA_DATA_W-1:0] avm_readdata,
  input  logic                       avm_readdatavalid,
  output logic [VRAM_AW-1:0]         h2f_vram_wraddr,
  output logic                       h2f_vram_wren,
  output logic [VRAM_DMA_DATA_W-1:0] h2f_vram_wrdata
`ifdef VRAM_DMA_PERF_EN
  ,
  output logic [31:0]                dma_cycles
`endif
);

  localparam int CNT_W = VRAM_AW + 1;

  dma_state_t          state;
  dma_state_t          state_nxt;
  logic [SDRAM_AW-1:0] base;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    ret_cnt;
  logic                start_acc;
  logic                rd_acc;
  logic                ret_vld;
  logic                cred_full;
  logic                last_issue;
  logic                last_ret;

  assign start_acc  = (state == IDLE) && dma_engine_start;
  assign rd_acc     = avm_read && !avm_waitrequest;
  assign ret_vld    = avm_readdatavalid && ((state == ISSUE) || (state == DRAIN));
  assign last_issue = (issue_cnt == CNT_W'(WORDS - 1));
  assign last_ret   = (ret_cnt == CNT_W'(WORDS - 1));

  vram_dma_credit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_acc),
    .inc  (rd_acc),
    .dec  (ret_vld),
    .full (cred_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Issue side only changes address on acceptance, so it stays stable under waitrequest.
  always_comb begin
    state_nxt         = state;
    avm_read          = 1'b0;
    avm_address       = '0;
    dma_engine_finish = 1'b0;
    dma_busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (dma_engine_start) state_nxt = ISSUE;
      end
      ISSUE: begin
        avm_read    = !cred_full;
        avm_address = base + SDRAM_AW'(issue_cnt);
        if (rd_acc && last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ret_vld && last_ret) state_nxt = DONE;
      end
      DONE: begin
        dma_engine_finish = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (start_acc) begin
      base      <= SDRAM_AW'(dma_engine_src_addr >> VRAM_DMA_BYTE_SHIFT);
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (rd_acc)  issue_cnt <= issue_cnt + CNT_W'(1);
      if (ret_vld) ret_cnt   <= ret_cnt + CNT_W'(1);
    end
  end

  // Responses are in order, so the return count is the VRAM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h2f_vram_wren   <= 1'b0;
      h2f_vram_wraddr <= '0;
      h2f_vram_wrdata <= '0;
    end else begin
      h2f_vram_wren <= ret_vld;
      if (ret_vld) begin
        h2f_vram_wraddr <= ret_cnt[VRAM_AW-1:0];
        h2f_vram_wrdata <= avm_readdata;
      end
    end
  end

`ifdef VRAM_DMA_PERF_EN
  // The start cycle counts as 1; every busy cycle through DONE adds one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_cycles <= '0;
    end else if (start_acc) begin
      dma_cycles <= 32'd1;
    end else if ((state != IDLE) && (dma_cycles != 32'hFFFF_FFFF)) begin
      dma_cycles <= dma_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/vram_dma_engine.md
Name: vram_dma_engine

Overview:
- Bulk copier between SDRAM and PPU VRAM.
- On a start pulse from the CPU-side control logic, it reads a contiguous VRAM image from HPS SDRAM over a 128-bit Avalon-MM read master (f2h SDRAM port).
- Each returned word is written into VRAM through the h2f VRAM write port, in order.
- Sits between the CPU/SDRAM fabric and the ppu. A one-cycle finish pulse feeds the ppu's DMA-ready interrupt logic.

Parameters:
- WORDS, 4096: 128-bit words per transfer; must equal VRAM depth (2^VRAM_AW).
- VRAM_AW, 12: VRAM word-address width.
- MAX_OUTSTANDING, 8: maximum accepted-but-unreturned reads; power of two, 2..64.
- SDRAM_AW, 28: Avalon word-address width (byte address >> 4).

Ports:
- clk  in  1  system clock (50 MHz fabric clock)
- rst_n  in  1  asynchronous active-low reset
- dma_engine_src_addr  in  32  SDRAM byte address of image; bits [3:0] ignored
- dma_engine_start  in  1  one-cycle start request
- dma_engine_finish  out  1  one-cycle pulse when the last VRAM write has been issued
- dma_busy  out  1  high from accepted start through the finish cycle
- avm_address  out  SDRAM_AW  Avalon word address
- avm_read  out  1  Avalon read request
- avm_waitrequest  in  1  Avalon stall
- avm_readdata  in  128  read data
- avm_readdatavalid  in  1  read data valid
- h2f_vram_wraddr  out  VRAM_AW  VRAM write address
- h2f_vram_wren  out  1  VRAM write enable
- h2f_vram_wrdata  out  128  VRAM write data

Behaviour:
- Reset: every output is 0; state is IDLE; all counters are 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - dma_engine_start latches base = src_addr[31:4] (truncated to SDRAM_AW).
  - Clears issue_cnt, ret_cnt and outstanding; moves to ISSUE next cycle.
- ISSUE:
  - avm_read = 1 when outstanding < MAX_OUTSTANDING; otherwise avm_read = 0.
  - avm_address = base + issue_cnt, modulo 2^SDRAM_AW (wraps silently).
  - Avalon rules: address and read are held stable while waitrequest = 1.
  - A read is accepted on a cycle with avm_read & !avm_waitrequest; acceptance increments issue_cnt.
  - When the accepted read is number WORDS, avm_read drops the next cycle and the FSM moves to DRAIN.
- Outstanding count:
  - +1 on acceptance, -1 on avm_readdatavalid.
  - Both in the same cycle: unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Return path (ISSUE and DRAIN):
  - avm_readdatavalid registers wrdata = readdata and wraddr = ret_cnt[VRAM_AW-1:0].
  - wren = 1 on the next cycle (fixed 1-cycle latency); ret_cnt increments.
  - Writes are in ascending address order; responses arrive in order per Avalon.
- DRAIN: when ret_cnt reaches WORDS, the FSM goes to DONE on the cycle that the final wren is asserted.
- DONE: dma_engine_finish = 1 for exactly one cycle, then IDLE. dma_busy = 0 from IDLE onward.
- Start while not IDLE (ISSUE/DRAIN/DONE): ignored, not queued.
- readdatavalid while IDLE: ignored; no write is issued.
- Reset mid-transfer:
  - Asynchronous return to IDLE; all outputs 0 immediately.
  - Abandoned reads are the interconnect's concern; the system resets both together.
- Counters are VRAM_AW+1 bits wide so that WORDS is representable.

Optional Feature:
- Macro: VRAM_DMA_PERF_EN.
- Defined:
  - Extra output dma_cycles [31:0].
  - Counts clk cycles from the accepted start through the DONE cycle inclusive.
  - Holds its value until the next accepted start; reset value 0.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package vram_dma_pkg:
  - dma_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
  - Localparams VRAM_DMA_DATA_W = 128 and VRAM_DMA_BYTE_SHIFT = 4.
- One natural sub-module, vram_dma_credit: outstanding-read counter with inc/dec inputs and a full flag.
- Address generation, FSM and return register stay in the top.

Test Plan:
- Zero-wait, 1-cycle read latency, WORDS=16 (bench override), src_addr=32'h1000_0000:
  - avm_address runs 28'h100_0000..28'h100_000F.
  - VRAM addresses 0..15 are written with the returned data.
  - Exactly one finish pulse; dma_busy is low afterwards.
- waitrequest high every other cycle:
  - avm_address and avm_read stay stable while stalled.
  - The total of 16 writes is still correct and in order.
- Read latency 20 cycles, MAX_OUTSTANDING=8:
  - avm_read deasserts at 8 outstanding; outstanding never exceeds 8.
  - All 16 words are written.
- Start pulsed again mid-ISSUE with src_addr=32'h2000_0000: ignored; the transfer completes from the original base.
- src_addr=32'hFFFF_FFF0, WORDS=4: addresses 28'hFFF_FFFF, 0, 1, 2 (wrap); finish asserts.
- rst_n low during DRAIN: all outputs 0 asynchronously; a new start after release completes normally. With VRAM_DMA_PERF_EN, dma_cycles equals the measured cycle count.
